// File: rtl/omp_supp_sel.sv
// OMP support selection: argmax of |correlation| over one stream of N_ATOMS samples,
// appended to the support-index RAM with a running support count.
module omp_supp_sel #(
    parameter int unsigned DWIDTH   = 32,
    parameter int unsigned AWIDTH   = 7,
    parameter int unsigned MEM_SIZE = 128,
    parameter int unsigned N_ATOMS  = 256,
    parameter int unsigned IWIDTH   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clear,
    input  logic [DWIDTH-1:0] corr_data,
    input  logic              corr_valid,
    output logic              corr_ready,
    output logic [AWIDTH-1:0] addr0,
    output logic              ce0,
    output logic              we0,
    output logic [DWIDTH-1:0] d0,
    output logic [AWIDTH:0]   supp_cnt,
    output logic [IWIDTH-1:0] sel_idx,
    output logic [DWIDTH-1:0] sel_mag,
    output logic              busy,
    output logic              full,
    output logic              done
);

    localparam int unsigned SWIDTH = AWIDTH + 1;

    typedef enum logic [1:0] {IDLE, SCAN, WRITE, DONE} state_t;

    state_t            state, state_nxt;
    logic [IWIDTH-1:0] cnt, best_idx, idx_nxt;
    logic [DWIDTH-1:0] best_mag, mag;
    logic              hs, last_beat, upd;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (!clear && start && !full) state_nxt = SCAN;
            SCAN:    if (last_beat) state_nxt = WRITE;
            WRITE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs; a reset in WRITE suppresses the RAM write that cycle
    always_comb begin
        corr_ready = (state == SCAN);
        busy       = (state == SCAN) || (state == WRITE);
        done       = (state == DONE);
        ce0        = (state == WRITE) && !rst;
        we0        = (state == WRITE) && !rst;
        full       = (supp_cnt == SWIDTH'(MEM_SIZE));
    end

    // Magnitude compare; the most negative sample maps to 2^(DWIDTH-1) unsaturated
    always_comb begin
        hs        = corr_valid && corr_ready;
        mag       = corr_data[DWIDTH-1] ? (~corr_data + DWIDTH'(1)) : corr_data;
        upd       = hs && (mag > best_mag);
        idx_nxt   = upd ? cnt : best_idx;
        last_beat = hs && (cnt == IWIDTH'(N_ATOMS - 1));
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            best_idx <= '0;
            best_mag <= '0;
            supp_cnt <= '0;
            sel_idx  <= '0;
            sel_mag  <= '0;
            addr0    <= '0;
            d0       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (clear) begin
                        supp_cnt <= '0;
                    end else if (start && !full) begin
                        cnt      <= '0;
                        best_idx <= '0;
                        best_mag <= '0;
                    end
                end
                SCAN: begin
                    if (hs) begin
                        cnt <= cnt + IWIDTH'(1);
                        if (upd) begin
                            best_mag <= mag;
                            best_idx <= cnt;
                        end
                        // Address and data are staged so they hold after the write
                        if (last_beat) begin
                            addr0 <= supp_cnt[AWIDTH-1:0];
                            d0    <= DWIDTH'(idx_nxt);
                        end
                    end
                end
                WRITE: begin
                    supp_cnt <= supp_cnt + SWIDTH'(1);
                    sel_idx  <= best_idx;
                    sel_mag  <= best_mag;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_omp_supp_sel.sv
// Directed bench for omp_supp_sel: argmax selection, RAM append, full/clear and reset behaviour.
module tb_omp_supp_sel;

    localparam int unsigned DWIDTH   = 32;
    localparam int unsigned AWIDTH   = 7;
    localparam int unsigned MEM_SIZE = 128;
    localparam int unsigned N_ATOMS  = 256;
    localparam int unsigned IWIDTH   = 8;

    logic              clk = 1'b0;
    logic              rst, start, clear, corr_valid;
    logic [DWIDTH-1:0] corr_data;
    logic              corr_ready, ce0, we0, busy, full, done;
    logic [AWIDTH-1:0] addr0;
    logic [DWIDTH-1:0] d0, sel_mag;
    logic [AWIDTH:0]   supp_cnt;
    logic [IWIDTH-1:0] sel_idx;

    omp_supp_sel #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .MEM_SIZE(MEM_SIZE),
                   .N_ATOMS(N_ATOMS), .IWIDTH(IWIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .corr_data(corr_data), .corr_valid(corr_valid), .corr_ready(corr_ready),
        .addr0(addr0), .ce0(ce0), .we0(we0), .d0(d0),
        .supp_cnt(supp_cnt), .sel_idx(sel_idx), .sel_mag(sel_mag),
        .busy(busy), .full(full), .done(done)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int hs_cnt = 0, wr_cnt = 0, done_cnt = 0, rdy_cnt = 0;
    int L;
    logic [DWIDTH-1:0] smp [N_ATOMS];
    logic              w_ce, w_we, got_done;
    logic [AWIDTH-1:0] w_addr;
    logic [DWIDTH-1:0] w_d;

    // Event counters, sampled mid-cycle
    always @(negedge clk) begin
        if (corr_valid && corr_ready) hs_cnt++;
        if (ce0 && we0) wr_cnt++;
        if (done) done_cnt++;
        if (corr_ready) rdy_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic zero_smp;
        for (int i = 0; i < int'(N_ATOMS); i++) smp[i] = '0;
    endtask

    task automatic feed(input int first, input int last, input int vpct, input bit mid_start);
        int i = first;
        int guard = 0;
        while (i < last && guard < 4000) begin
            corr_data  = smp[i];
            corr_valid = (vpct >= 100) ? 1'b1 : (int'($urandom_range(99)) < vpct);
            if (mid_start) start = (i >= 50 && i < 53);
            tick;
            guard++;
            L++;
            if (corr_valid) i++;
        end
        corr_valid = 1'b0;
        corr_data  = '0;
        start      = 1'b0;
        if (i < last) begin
            nvec++; nerr++;
            $display("FAIL feed_timeout: accepted %0d of %0d", i, last);
        end
    endtask

    task automatic run_iter(input int vpct, input bit mid_start, output int total);
        int k;
        L = 0;
        start = 1'b1;
        tick;
        start = 1'b0;
        feed(0, N_ATOMS, vpct, mid_start);
        w_ce = ce0; w_we = we0; w_addr = addr0; w_d = d0;
        k = 0;
        do begin tick; k++; end while (!done && k < 6);
        got_done = done;
        total = 2 + L + k;
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; clear = 1'b0; corr_valid = 1'b0; corr_data = '0;
        tick; tick;
        rst = 1'b0;
        tick;
        nvec++; if (supp_cnt !== '0 || sel_idx !== '0 || sel_mag !== '0) begin
            nerr++; $display("FAIL reset_regs: cnt=%0d idx=%0d mag=%0d exp 0", supp_cnt, sel_idx, sel_mag); end
        nvec++; if ({corr_ready, ce0, we0, busy, done, full} !== 6'b0) begin
            nerr++; $display("FAIL reset_flags: got %b exp 000000", {corr_ready, ce0, we0, busy, done, full}); end
        nvec++; if (addr0 !== '0 || d0 !== '0) begin
            nerr++; $display("FAIL reset_ram_bus: addr0=%0d d0=%0d exp 0", addr0, d0); end
    endtask

    task automatic test_basic;
        int t;
        int wr0 = wr_cnt;
        zero_smp();
        smp[37]  = -32'sd500;
        smp[200] = 32'sd499;
        run_iter(100, 1'b0, t);
        nvec++; if (w_ce !== 1'b1 || w_we !== 1'b1) begin
            nerr++; $display("FAIL basic_write_en: ce0=%b we0=%b exp 1 1", w_ce, w_we); end
        nvec++; if (w_addr !== 7'd0 || w_d !== 32'd37) begin
            nerr++; $display("FAIL basic_write_data: addr0=%0d d0=%0d exp 0 37", w_addr, w_d); end
        nvec++; if (t !== 259 || got_done !== 1'b1) begin
            nerr++; $display("FAIL basic_latency: cycles=%0d done=%b exp 259 1", t, got_done); end
        nvec++; if (supp_cnt !== 8'd1 || sel_idx !== 8'd37 || sel_mag !== 32'd500) begin
            nerr++; $display("FAIL basic_result: cnt=%0d idx=%0d mag=%0d exp 1 37 500", supp_cnt, sel_idx, sel_mag); end
        nvec++; if (wr_cnt - wr0 !== 1) begin
            nerr++; $display("FAIL basic_write_count: got %0d exp 1", wr_cnt - wr0); end
    endtask

    task automatic test_tie_and_minval;
        int t;
        zero_smp();
        smp[5] = 32'sd1000;
        smp[9] = -32'sd1000;
        run_iter(100, 1'b0, t);
        nvec++; if (sel_idx !== 8'd5 || sel_mag !== 32'd1000 || w_addr !== 7'd1) begin
            nerr++; $display("FAIL tie_lowest: idx=%0d mag=%0d addr=%0d exp 5 1000 1", sel_idx, sel_mag, w_addr); end
        zero_smp();
        smp[100] = 32'h8000_0000;
        smp[101] = 32'h7FFF_FFFF;
        run_iter(100, 1'b0, t);
        nvec++; if (sel_idx !== 8'd100 || sel_mag !== 32'h8000_0000 || supp_cnt !== 8'd3) begin
            nerr++; $display("FAIL min_value: idx=%0d mag=%h cnt=%0d exp 100 80000000 3", sel_idx, sel_mag, supp_cnt); end
    endtask

    task automatic test_random_valid;
        int     t, bi;
        longint best, v;
        int     hs0 = hs_cnt;
        for (int i = 0; i < int'(N_ATOMS); i++) smp[i] = $urandom;
        best = 0; bi = 0;
        for (int i = 0; i < int'(N_ATOMS); i++) begin
            v = longint'(signed'(smp[i]));
            if (v < 0) v = -v;
            if (v > best) begin best = v; bi = i; end
        end
        run_iter(50, 1'b0, t);
        nvec++; if (hs_cnt - hs0 !== 256) begin
            nerr++; $display("FAIL rand_handshakes: got %0d exp 256", hs_cnt - hs0); end
        nvec++; if (sel_idx !== 8'(bi) || sel_mag !== 32'(best)) begin
            nerr++; $display("FAIL rand_argmax: idx=%0d mag=%h exp %0d %h", sel_idx, sel_mag, bi, 32'(best)); end
        nvec++; if (t !== L + 3) begin
            nerr++; $display("FAIL rand_latency: cycles=%0d exp %0d", t, L + 3); end
    endtask

    task automatic test_back_to_back;
        int t, wr0, dn0, rd0;
        clear = 1'b1; tick; clear = 1'b0;
        wr0 = wr_cnt;
        for (int k = 0; k < int'(MEM_SIZE); k++) begin
            zero_smp();
            smp[k] = DWIDTH'(k + 1);
            run_iter(100, 1'b0, t);
            nvec++; if (w_addr !== AWIDTH'(k) || w_d !== DWIDTH'(k)) begin
                nerr++; $display("FAIL b2b_write_%0d: addr0=%0d d0=%0d exp %0d %0d", k, w_addr, w_d, k, k); end
        end
        nvec++; if (full !== 1'b1 || supp_cnt !== 8'd128 || wr_cnt - wr0 !== 128) begin
            nerr++; $display("FAIL b2b_full: full=%b cnt=%0d writes=%0d exp 1 128 128", full, supp_cnt, wr_cnt - wr0); end
        wr0 = wr_cnt; dn0 = done_cnt; rd0 = rdy_cnt;
        start = 1'b1; tick; start = 1'b0;
        repeat (300) tick;
        nvec++; if (rdy_cnt - rd0 !== 0 || wr_cnt - wr0 !== 0 || done_cnt - dn0 !== 0 || full !== 1'b1) begin
            nerr++; $display("FAIL full_start_ignored: scan=%0d writes=%0d dones=%0d full=%b exp 0 0 0 1",
                             rdy_cnt - rd0, wr_cnt - wr0, done_cnt - dn0, full); end
        clear = 1'b1; tick; clear = 1'b0;
        nvec++; if (supp_cnt !== 8'd0 || full !== 1'b0) begin
            nerr++; $display("FAIL clear_after_full: cnt=%0d full=%b exp 0 0", supp_cnt, full); end
    endtask

    task automatic test_reset_mid;
        int t, wr0;
        zero_smp();
        smp[150] = -32'sd7;
        run_iter(100, 1'b0, t);
        wr0 = wr_cnt;
        start = 1'b1; tick; start = 1'b0;
        L = 0;
        feed(0, 100, 100, 1'b0);
        rst = 1'b1; corr_valid = 1'b1; corr_data = smp[100];
        tick;
        rst = 1'b0; corr_valid = 1'b0;
        nvec++; if (corr_ready !== 1'b0 || busy !== 1'b0 || supp_cnt !== 8'd0 || sel_idx !== 8'd0) begin
            nerr++; $display("FAIL rst_scan: ready=%b busy=%b cnt=%0d idx=%0d exp 0 0 0 0", corr_ready, busy, supp_cnt, sel_idx); end
        start = 1'b1; tick; start = 1'b0;
        feed(0, N_ATOMS, 100, 1'b0);
        rst = 1'b1;
        #1;
        nvec++; if (ce0 !== 1'b0 || we0 !== 1'b0) begin
            nerr++; $display("FAIL rst_write_gate: ce0=%b we0=%b exp 0 0", ce0, we0); end
        tick;
        rst = 1'b0;
        nvec++; if (supp_cnt !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || wr_cnt - wr0 !== 0) begin
            nerr++; $display("FAIL rst_write: cnt=%0d busy=%b done=%b writes=%0d exp 0 0 0 0", supp_cnt, busy, done, wr_cnt - wr0); end
        run_iter(100, 1'b0, t);
        nvec++; if (sel_idx !== 8'd150 || sel_mag !== 32'd7 || w_addr !== 7'd0 || supp_cnt !== 8'd1) begin
            nerr++; $display("FAIL rst_fresh: idx=%0d mag=%0d addr=%0d cnt=%0d exp 150 7 0 1", sel_idx, sel_mag, w_addr, supp_cnt); end
    endtask

    task automatic test_start_clear;
        int t, rd0, dn0;
        run_iter(100, 1'b0, t);
        run_iter(100, 1'b0, t);
        nvec++; if (supp_cnt !== 8'd3) begin
            nerr++; $display("FAIL sc_precount: got %0d exp 3", supp_cnt); end
        rd0 = rdy_cnt; dn0 = done_cnt;
        start = 1'b1; clear = 1'b1; tick; start = 1'b0; clear = 1'b0;
        repeat (5) tick;
        nvec++; if (supp_cnt !== 8'd0 || busy !== 1'b0 || rdy_cnt - rd0 !== 0 || done_cnt - dn0 !== 0) begin
            nerr++; $display("FAIL clear_prio: cnt=%0d busy=%b scan=%0d dones=%0d exp 0 0 0 0",
                             supp_cnt, busy, rdy_cnt - rd0, done_cnt - dn0); end
        zero_smp();
        smp[20] = 32'sd300;
        smp[60] = -32'sd299;
        run_iter(100, 1'b1, t);
        nvec++; if (sel_idx !== 8'd20 || sel_mag !== 32'd300 || supp_cnt !== 8'd1 || t !== 259) begin
            nerr++; $display("FAIL start_in_scan: idx=%0d mag=%0d cnt=%0d cycles=%0d exp 20 300 1 259", sel_idx, sel_mag, supp_cnt, t); end
        zero_smp();
        run_iter(100, 1'b0, t);
        nvec++; if (sel_idx !== 8'd0 || sel_mag !== 32'd0 || w_d !== 32'd0 || w_addr !== 7'd1) begin
            nerr++; $display("FAIL all_zero: idx=%0d mag=%0d d0=%0d addr=%0d exp 0 0 0 1", sel_idx, sel_mag, w_d, w_addr); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie_and_minval();
        test_random_valid();
        test_back_to_back();
        test_reset_mid();
        test_start_clear();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/omp_supp_sel.md
Name: omp_supp_sel

Overview:
Support-selection stage of the OMP solver, directly upstream of the support-index RAM. Each iteration it consumes one full stream of N_ATOMS correlation values and finds the atom index with the largest absolute correlation. It then appends that index to the support RAM through the RAM's single port (addr0/ce0/we0/d0) and keeps the running support count for the least-squares stage downstream.

Parameters:
DWIDTH, 32, width of correlation samples (signed two's complement) and of RAM data word
AWIDTH, 7, support RAM address width
MEM_SIZE, 128, support RAM depth = maximum support size (<= 2^AWIDTH)
N_ATOMS, 256, correlation samples per iteration (>= 1)
IWIDTH, 8, atom index width (2^IWIDTH >= N_ATOMS, IWIDTH <= DWIDTH)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
start  in  1  begin one selection iteration (sampled in IDLE only)
clear  in  1  zero the support count (sampled in IDLE only)
corr_data  in  DWIDTH  signed correlation sample
corr_valid  in  1  corr_data valid
corr_ready  out  1  sample accepted when corr_valid & corr_ready
addr0  out  AWIDTH  support RAM address
ce0  out  1  support RAM enable
we0  out  1  support RAM write enable
d0  out  DWIDTH  support RAM write data (index, zero-extended)
supp_cnt  out  AWIDTH+1  number of indices written so far
sel_idx  out  IWIDTH  index selected in the last completed iteration
sel_mag  out  DWIDTH  |correlation| of sel_idx, unsigned
busy  out  1  high in SCAN and WRITE
full  out  1  supp_cnt == MEM_SIZE
done  out  1  one-cycle pulse at end of iteration

Behaviour:
- Reset: state IDLE. All outputs 0: supp_cnt, sel_idx, sel_mag, corr_ready, ce0, we0, addr0, d0, busy, done. Internal best_mag, best_idx and the sample counter are also 0.
- States: IDLE, SCAN, WRITE, DONE.
- IDLE:
  - If clear=1, supp_cnt<=0. clear has priority over start in the same cycle, and start is ignored that cycle.
  - Else if start=1 and full=0: go to SCAN; best_mag<=0, best_idx<=0, sample counter<=0.
  - start while full=1 is ignored; the block stays in IDLE and done is not asserted.
- SCAN:
  - corr_ready=1 combinationally while in SCAN. corr_valid may be deasserted at any time; idle cycles do not count as samples.
  - On each handshake, mag = |corr_data| as an unsigned DWIDTH value. -2^(DWIDTH-1) maps to 2^(DWIDTH-1) with no saturation.
  - If mag > best_mag (strict), update best_mag and best_idx to the current counter value. Ties keep the lowest index. An all-zero stream selects index 0.
  - The counter wraps nowhere. On the N_ATOMS-th handshake, the compare still applies, then go to WRITE.
- WRITE (exactly 1 cycle):
  - ce0=1, we0=1, addr0=supp_cnt[AWIDTH-1:0], d0=zero-extended best_idx.
  - supp_cnt<=supp_cnt+1, sel_idx<=best_idx, sel_mag<=best_mag.
- DONE (1 cycle): done=1, then IDLE.
- Outside WRITE, ce0=we0=0. addr0 and d0 hold their last values.
- Latency: last sample accepted in cycle t -> RAM write in t+1 -> done in t+2. supp_cnt, sel_idx and sel_mag are already updated when done=1. The minimum iteration is N_ATOMS+3 cycles from start (IDLE, N_ATOMS scan cycles, WRITE, DONE).
- start and clear while busy or in DONE are ignored.
- rst mid-SCAN or in WRITE: returns to IDLE next edge with all outputs 0. The rst cycle itself wins over the RAM write, so ce0=we0=0 that cycle.
- full asserts combinationally once supp_cnt reaches MEM_SIZE and remains until clear or rst.
- Duplicate indices are not filtered; that is guaranteed by the residual orthogonality upstream.

Test Plan:
1. rst, then start with N_ATOMS=256 and samples all 0 except sample 37=-500 and sample 200=+499 -> WRITE cycle with addr0=0 and d0=37; done 2 cycles after the last beat; supp_cnt=1, sel_mag=500.
2. Tie: samples 5=+1000 and 9=-1000, all others 0 -> sel_idx=5. Most-negative value -2^31 at index 100 -> sel_idx=100, sel_mag=0x80000000.
3. corr_valid toggled 50% randomly -> exactly 256 handshakes accepted. Result matches the reference argmax, and the cycle count from start to done equals the number of SCAN cycles + 3.
4. Run 128 back-to-back iterations -> writes to addr0 0..127, full=1, supp_cnt=128. A further start produces no SCAN, no ce0 and no done. clear -> supp_cnt=0, full=0.
5. rst asserted at sample 100 of a scan -> next cycle state IDLE, supp_cnt=0, corr_ready=0, and no RAM write. A fresh iteration afterwards is correct.
6. start and clear asserted together in IDLE with supp_cnt=3 -> supp_cnt=0, remains IDLE. start pulsed during SCAN -> no effect on the result.
